// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate-generation stage with a 2-entry skid buffer.
// Decodes format, immediate and legality combinationally, then stores the decoded beat.
module imm_gen_pipe #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc
);

   typedef enum logic [2:0] {
      FMT_R       = 3'd0,
      FMT_I       = 3'd1,
      FMT_S       = 3'd2,
      FMT_B       = 3'd3,
      FMT_U       = 3'd4,
      FMT_J       = 3'd5,
      FMT_SHAMT   = 3'd6,
      FMT_UNKNOWN = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      fmt_e            fmt;
      logic            illegal;
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
   } beat_t;

   logic signed [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [5:0]         w_sh_op, w_sh_w;
   logic [6:0]         w_opcode;
   logic [2:0]         w_func3;
   logic               w_is_shift;
   beat_t              w_dec;

   assign w_opcode   = in_instr[6:0];
   assign w_func3    = in_instr[14:12];
   assign w_is_shift = (w_func3 == 3'b001) || (w_func3 == 3'b101);

   // Every immediate is first built sign-extended to 32 bits; the signed cast widens to XLEN.
   assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
   assign w_imm_u = {in_instr[31:12], 12'b0};
   assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};

   // OP-IMM shifts take a 6-bit shamt only on RV64; the W-form shifts are always 5-bit.
   assign w_sh_op = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};
   assign w_sh_w  = {1'b0, in_instr[24:20]};

   // NOTE: every field gets a default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      w_dec.instr   = in_instr;
      w_dec.pc      = in_pc;
      w_dec.imm     = '0;
      w_dec.fmt     = FMT_UNKNOWN;
      w_dec.illegal = 1'b1;
      case (w_opcode)
         7'b0110011: begin
            w_dec.fmt     = FMT_R;
            w_dec.illegal = 1'b0;
         end
         7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
            w_dec.fmt     = FMT_I;
            w_dec.imm     = XLEN'(w_imm_i);
            w_dec.illegal = 1'b0;
         end
         7'b0100011: begin
            w_dec.fmt     = FMT_S;
            w_dec.imm     = XLEN'(w_imm_s);
            w_dec.illegal = 1'b0;
         end
         7'b1100011: begin
            w_dec.fmt     = FMT_B;
            w_dec.imm     = XLEN'(w_imm_b);
            w_dec.illegal = 1'b0;
         end
         7'b0110111, 7'b0010111: begin
            w_dec.fmt     = FMT_U;
            w_dec.imm     = XLEN'(w_imm_u);
            w_dec.illegal = 1'b0;
         end
         7'b1101111: begin
            w_dec.fmt     = FMT_J;
            w_dec.imm     = XLEN'(w_imm_j);
            w_dec.illegal = 1'b0;
         end
         7'b0010011: begin
            w_dec.illegal = 1'b0;
            if (w_is_shift) begin
               w_dec.fmt = FMT_SHAMT;
               w_dec.imm = XLEN'(w_sh_op);
            end else begin
               w_dec.fmt = FMT_I;
               w_dec.imm = XLEN'(w_imm_i);
            end
         end
         7'b0111011: begin
            if (XLEN == 64) begin
               w_dec.fmt     = FMT_R;
               w_dec.illegal = 1'b0;
            end
         end
         7'b0011011: begin
            if (XLEN == 64) begin
               w_dec.illegal = 1'b0;
               if (w_is_shift) begin
                  w_dec.fmt = FMT_SHAMT;
                  w_dec.imm = XLEN'(w_sh_w);
               end else begin
                  w_dec.fmt = FMT_I;
                  w_dec.imm = XLEN'(w_imm_i);
               end
            end
         end
         default: ;
      endcase
   end

   logic  r_main_valid, r_skid_valid;
   beat_t r_main, r_skid;
   logic  w_accept, w_consume;

   assign in_ready  = ~r_skid_valid;
   assign w_accept  = in_valid && in_ready && !flush;
   assign w_consume = r_main_valid && out_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the data registers are reset too, because the outputs must read zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_main       <= '0;
         r_skid       <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_consume && r_skid_valid) begin
         // in_ready is low here, so no new beat can compete with the skid entry
         r_main       <= r_skid;
         r_skid_valid <= 1'b0;
      end else if (w_accept && (!r_main_valid || w_consume)) begin
         r_main       <= w_dec;
         r_main_valid <= 1'b1;
      end else if (w_accept) begin
         r_skid       <= w_dec;
         r_skid_valid <= 1'b1;
      end else if (w_consume) begin
         r_main_valid <= 1'b0;
      end
   end

   assign out_valid   = r_main_valid;
   assign out_imm     = r_main.imm;
   assign out_fmt     = r_main.fmt;
   assign out_illegal = r_main.illegal;
   assign out_instr   = r_main.instr;
   assign out_pc      = r_main.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lock-step,
// each checked by a reference decoder feeding a FIFO scoreboard plus directed checks.
module tb_imm_gen_pipe;

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
      logic [31:0] instr;
      logic [63:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [63:0] in_pc = '0;
   logic        out_ready = 1'b0;

   logic        d32_in_ready, d32_out_valid, d32_out_illegal;
   logic [31:0] d32_out_imm, d32_out_instr, d32_out_pc;
   logic [2:0]  d32_out_fmt;
   logic        d64_in_ready, d64_out_valid, d64_out_illegal;
   logic [63:0] d64_out_imm, d64_out_pc;
   logic [31:0] d64_out_instr;
   logic [2:0]  d64_out_fmt;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t q32[$];
   exp_t q64[$];

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(d32_in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
      .out_valid(d32_out_valid), .out_ready(out_ready), .out_imm(d32_out_imm),
      .out_fmt(d32_out_fmt), .out_illegal(d32_out_illegal), .out_instr(d32_out_instr),
      .out_pc(d32_out_pc)
   );

   imm_gen_pipe #(.XLEN(64)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(d64_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(d64_out_valid), .out_ready(out_ready), .out_imm(d64_out_imm),
      .out_fmt(d64_out_fmt), .out_illegal(d64_out_illegal), .out_instr(d64_out_instr),
      .out_pc(d64_out_pc)
   );

   // Reference decoder: builds every immediate directly at 64 bits.
   function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input bit x64);
      exp_t        e;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [63:0] ii, is, ib, iu, ij;
      op = ins[6:0];
      f3 = ins[14:12];
      ii = {{52{ins[31]}}, ins[31:20]};
      is = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      ib = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      iu = {{32{ins[31]}}, ins[31:12], 12'h000};
      ij = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      e.instr = ins;
      e.pc    = pc;
      e.imm   = 64'd0;
      e.fmt   = 3'd7;
      e.ill   = 1'b1;
      if (op == 7'h33 || (x64 && op == 7'h3B)) begin
         e.fmt = 3'd0; e.ill = 1'b0;
      end else if (op == 7'h03 || op == 7'h67 || op == 7'h0F || op == 7'h73) begin
         e.fmt = 3'd1; e.ill = 1'b0; e.imm = ii;
      end else if (op == 7'h23) begin
         e.fmt = 3'd2; e.ill = 1'b0; e.imm = is;
      end else if (op == 7'h63) begin
         e.fmt = 3'd3; e.ill = 1'b0; e.imm = ib;
      end else if (op == 7'h37 || op == 7'h17) begin
         e.fmt = 3'd4; e.ill = 1'b0; e.imm = iu;
      end else if (op == 7'h6F) begin
         e.fmt = 3'd5; e.ill = 1'b0; e.imm = ij;
      end else if (op == 7'h13 || (x64 && op == 7'h1B)) begin
         e.ill = 1'b0;
         if (f3 == 3'd1 || f3 == 3'd5) begin
            e.fmt = 3'd6;
            e.imm = (x64 && op == 7'h13) ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
         end else begin
            e.fmt = 3'd1; e.imm = ii;
         end
      end
      return e;
   endfunction

   // Scoreboard: push on accept, pop and compare on output handshake, all sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q32.delete();
         q64.delete();
      end else begin
         if (d32_out_valid && out_ready) begin
            n_checks++;
            if (q32.size() == 0) begin
               n_fail++;
               $display("FAIL sb32_unexpected got instr=%h pc=%h, required no beat", d32_out_instr, d32_out_pc);
            end else begin
               e = q32.pop_front();
               if ({d32_out_imm, d32_out_fmt, d32_out_illegal, d32_out_instr, d32_out_pc} !==
                   {e.imm[31:0], e.fmt, e.ill, e.instr, e.pc[31:0]}) begin
                  n_fail++;
                  $display("FAIL sb32 got imm=%h fmt=%0d ill=%0b instr=%h pc=%h, required imm=%h fmt=%0d ill=%0b instr=%h pc=%h",
                           d32_out_imm, d32_out_fmt, d32_out_illegal, d32_out_instr, d32_out_pc,
                           e.imm[31:0], e.fmt, e.ill, e.instr, e.pc[31:0]);
               end
            end
         end
         if (d64_out_valid && out_ready) begin
            n_checks++;
            if (q64.size() == 0) begin
               n_fail++;
               $display("FAIL sb64_unexpected got instr=%h pc=%h, required no beat", d64_out_instr, d64_out_pc);
            end else begin
               e = q64.pop_front();
               if ({d64_out_imm, d64_out_fmt, d64_out_illegal, d64_out_instr, d64_out_pc} !==
                   {e.imm, e.fmt, e.ill, e.instr, e.pc}) begin
                  n_fail++;
                  $display("FAIL sb64 got imm=%h fmt=%0d ill=%0b instr=%h pc=%h, required imm=%h fmt=%0d ill=%0b instr=%h pc=%h",
                           d64_out_imm, d64_out_fmt, d64_out_illegal, d64_out_instr, d64_out_pc,
                           e.imm, e.fmt, e.ill, e.instr, e.pc);
               end
            end
         end
         if (flush) begin
            q32.delete();
            q64.delete();
         end else begin
            if (in_valid && d32_in_ready) q32.push_back(model(in_instr, in_pc, 1'b0));
            if (in_valid && d64_in_ready) q64.push_back(model(in_instr, in_pc, 1'b1));
         end
      end
   end

   // Offers one beat and returns #1 after the edge that accepted it; in_valid stays high.
   task automatic send(input logic [31:0] ins, input logic [63:0] pc);
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      do begin
         @(negedge clk);
         acc = d32_in_ready && !flush;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      n_checks++;
      if (!acc) begin
         n_fail++;
         $display("FAIL send_timeout instr=%h not accepted after %0d cycles, required acceptance", ins, n);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({d32_out_valid, d32_in_ready, d32_out_imm, d32_out_fmt, d32_out_illegal, d32_out_instr, d32_out_pc}
          !== {1'b0, 1'b1, 32'd0, 3'd0, 1'b0, 32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL reset32 got valid=%0b ready=%0b imm=%h fmt=%0d ill=%0b instr=%h pc=%h, required valid=0 ready=1 rest 0",
                  d32_out_valid, d32_in_ready, d32_out_imm, d32_out_fmt, d32_out_illegal, d32_out_instr, d32_out_pc);
      end
      n_checks++;
      if ({d64_out_valid, d64_in_ready, d64_out_imm, d64_out_fmt, d64_out_illegal, d64_out_instr, d64_out_pc}
          !== {1'b0, 1'b1, 64'd0, 3'd0, 1'b0, 32'd0, 64'd0}) begin
         n_fail++;
         $display("FAIL reset64 got valid=%0b ready=%0b imm=%h fmt=%0d ill=%0b instr=%h pc=%h, required valid=0 ready=1 rest 0",
                  d64_out_valid, d64_in_ready, d64_out_imm, d64_out_fmt, d64_out_illegal, d64_out_instr, d64_out_pc);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_formats;
      logic [31:0] t_ins  [10] = '{32'hFFF00093, 32'hFE000EE3, 32'hFF9FF06F, 32'h4030D093, 32'h0000003B,
                                   32'h800000B7, 32'h03F09093, 32'h0200101B, 32'hFFF00091, 32'hFE112E23};
      logic [31:0] t_i32  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h3, 32'h0,
                                   32'h80000000, 32'h1F, 32'h0, 32'h0, 32'hFFFFFFFC};
      logic [2:0]  t_f32  [10] = '{3'd1, 3'd3, 3'd5, 3'd6, 3'd7, 3'd4, 3'd6, 3'd7, 3'd7, 3'd2};
      logic        t_l32  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [63:0] t_i64  [10] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8, 64'h3, 64'h0,
                                   64'hFFFFFFFF80000000, 64'h3F, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFC};
      logic [2:0]  t_f64  [10] = '{3'd1, 3'd3, 3'd5, 3'd6, 3'd0, 3'd4, 3'd6, 3'd6, 3'd7, 3'd2};
      logic        t_l64  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [63:0] pc;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pc = 64'hFFFF_0000_0000_1000 + 64'(i * 4);
         send(t_ins[i], pc);
         in_valid = 1'b0;
         n_checks++;
         if ({d32_out_valid, d32_out_imm, d32_out_fmt, d32_out_illegal, d32_out_pc}
             !== {1'b1, t_i32[i], t_f32[i], t_l32[i], pc[31:0]}) begin
            n_fail++;
            $display("FAIL fmt32[%0d] instr=%h got valid=%0b imm=%h fmt=%0d ill=%0b pc=%h, required valid=1 imm=%h fmt=%0d ill=%0b pc=%h",
                     i, t_ins[i], d32_out_valid, d32_out_imm, d32_out_fmt, d32_out_illegal, d32_out_pc,
                     t_i32[i], t_f32[i], t_l32[i], pc[31:0]);
         end
         n_checks++;
         if ({d64_out_valid, d64_out_imm, d64_out_fmt, d64_out_illegal, d64_out_pc}
             !== {1'b1, t_i64[i], t_f64[i], t_l64[i], pc}) begin
            n_fail++;
            $display("FAIL fmt64[%0d] instr=%h got valid=%0b imm=%h fmt=%0d ill=%0b pc=%h, required valid=1 imm=%h fmt=%0d ill=%0b pc=%h",
                     i, t_ins[i], d64_out_valid, d64_out_imm, d64_out_fmt, d64_out_illegal, d64_out_pc,
                     t_i64[i], t_f64[i], t_l64[i], pc);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, b, c;
      a = 32'h00100093;
      b = 32'h00200113;
      c = 32'h00300193;
      out_ready = 1'b0;
      send(a, 64'h100);
      send(b, 64'h104);
      in_instr = c;
      in_pc    = 64'h108;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if ({d32_in_ready, d32_out_valid, d32_out_instr, d64_out_instr, d64_out_pc}
             !== {1'b0, 1'b1, a, a, 64'h100}) begin
            n_fail++;
            $display("FAIL hold[%0d] got ready=%0b valid=%0b instr32=%h instr64=%h pc64=%h, required ready=0 valid=1 instr=%h pc=100",
                     k, d32_in_ready, d32_out_valid, d32_out_instr, d64_out_instr, d64_out_pc, a);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({d32_out_valid, d32_out_instr, d32_out_pc, d64_out_pc} !== {1'b1, b, 32'h104, 64'h104}) begin
         n_fail++;
         $display("FAIL drain_b got valid=%0b instr=%h pc32=%h pc64=%h, required valid=1 instr=%h pc=104",
                  d32_out_valid, d32_out_instr, d32_out_pc, d64_out_pc, b);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_checks++;
      if ({d32_out_valid, d32_out_instr, d32_out_pc, d64_out_pc} !== {1'b1, c, 32'h108, 64'h108}) begin
         n_fail++;
         $display("FAIL drain_c got valid=%0b instr=%h pc32=%h pc64=%h, required valid=1 instr=%h pc=108",
                  d32_out_valid, d32_out_instr, d32_out_pc, d64_out_pc, c);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (d32_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_empty got valid=%0b, required 0", d32_out_valid);
      end
   endtask

   task automatic test_flush;
      // Pass 0: both entries full; pass 1: only main full, so the flush-cycle beat would otherwise be accepted.
      for (int p = 0; p < 2; p++) begin
         out_ready = 1'b0;
         send(32'h00A00513, 64'h200);
         if (p == 0) send(32'h00B00593, 64'h204);
         in_instr = 32'h00C00613;
         in_pc    = 64'h208;
         flush    = 1'b1;
         @(posedge clk);
         #1;
         flush    = 1'b0;
         in_valid = 1'b0;
         out_ready = 1'b1;
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({d32_out_valid, d32_in_ready, d64_out_valid, d64_in_ready} !== 4'b0101) begin
               n_fail++;
               $display("FAIL flush[%0d.%0d] got v32=%0b r32=%0b v64=%0b r64=%0b, required valid=0 ready=1",
                        p, k, d32_out_valid, d32_in_ready, d64_out_valid, d64_in_ready);
            end
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      send(32'h123450B7, 64'h300);
      send(32'h00500693, 64'h304);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({d32_out_valid, d32_in_ready, d32_out_imm, d32_out_instr, d64_out_valid, d64_out_imm, d64_out_pc, d64_out_fmt}
          !== {1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 64'd0, 64'd0, 3'd0}) begin
         n_fail++;
         $display("FAIL reset_mid got v32=%0b r32=%0b imm32=%h instr32=%h v64=%0b imm64=%h pc64=%h fmt64=%0d, required valid=0 ready=1 rest 0",
                  d32_out_valid, d32_in_ready, d32_out_imm, d32_out_instr, d64_out_valid, d64_out_imm, d64_out_pc, d64_out_fmt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({d32_out_valid, d64_out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset[%0d] got v32=%0b v64=%0b, required 0", k, d32_out_valid, d64_out_valid);
         end
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [12] = '{7'h33, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13, 7'h3B};
      logic [31:0] r;
      logic [6:0]  op;
      r = $urandom();
      case ($urandom_range(0, 7))
         0:       op = r[6:0];
         1:       op = 7'h1B;
         2:       op = 7'h13;
         default: op = ops[$urandom_range(0, 11)];
      endcase
      return {r[31:7], op};
   endfunction

   task automatic test_random;
      int n;
      for (int k = 0; k < 600; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 59) == 0);
         in_instr  = rand_instr();
         in_pc     = {$urandom(), $urandom()};
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((q32.size() != 0 || q64.size() != 0) && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_checks++;
      if (q32.size() != 0 || q64.size() != 0 || d32_out_valid !== 1'b0 || d64_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_random got pending32=%0d pending64=%0d v32=%0b v64=%0b, required all empty",
                  q32.size(), q64.size(), d32_out_valid, d64_out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_formats();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_random();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate-generation stage for the decode pipeline. It takes whole 32-bit RV32I/RV64I instruction words with their PC, extracts and sign/zero-extends the immediate to XLEN, classifies the format, and flags unsupported encodings. The result is presented one cycle later on a valid/ready interface. A 2-entry skid buffer sustains full throughput under back-pressure, and a synchronous flush discards in-flight entries on redirect.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries and the current input beat.
- in_valid  in  1  input beat present.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC, passed through.
- out_valid  out  1  output beat present.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  generated immediate.
- out_fmt  out  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 UNKNOWN.
- out_illegal  out  1  encoding not supported at this XLEN.
- out_instr  out  32  instruction, passed through.
- out_pc  out  XLEN  PC, passed through.

## Operation
- Fields are taken from in_instr bit positions. sext/zext extend to XLEN.
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25],instr[11:7]}).
  - B: sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
  - U: sext({instr[31:12],12'b0}).
  - J: sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
- Opcode map:
  - 0110011 → R (imm 0).
  - 0000011, 1100111, 0001111, 1110011 → I.
  - 0100011 → S. 1100011 → B.
  - 0110111, 0010111 → U. 1101111 → J.
  - 0010011 → I, except func3 001/101 → SHAMT.
  - XLEN=64 only: 0111011 → R; 0011011 → I, except func3 001/101 → SHAMT.
- SHAMT width:
  - zext(instr[24:20]) for XLEN=32 and for opcode 0011011.
  - zext(instr[25:20]) for opcode 0010011 at XLEN=64.
  - instr[31:26] is ignored.
- Any other opcode, or instr[1:0]≠2'b11 → fmt 7, imm 0, illegal 1. The beat still propagates.
- Storage is a main register (drives outputs) plus a skid register.
  - Input accepted when in_valid && in_ready && !flush.
  - Output consumed when out_valid && out_ready.
- Accept rules:
  - Main empty, or main consumed this cycle with skid empty → load main.
  - Main full and not consumed → load skid.
- Main consumed while skid full → skid moves to main. A simultaneous accept is impossible because in_ready=0.
- Order is strictly FIFO, with no reordering or duplication.
- flush has priority over everything. Next cycle main_valid=skid_valid=0 and in_ready=1. The flush-cycle input beat is dropped. An out handshake in the flush cycle counts as consumed.

## Timing
- Reset (async assert, sync-safe deassert):
  - out_valid=0, in_ready=1, skid_valid=0.
  - out_imm, out_fmt, out_illegal, out_instr, out_pc = 0.
- Latency: beat accepted at edge N appears at out at edge N (registered), i.e. visible cycle N+1. No combinational path from in_* to out_*.
- Throughput: 1 beat/cycle while out_ready=1.
- Decode is combinational on in_instr before the main/skid registers; both registers store decoded results.
- out_* are stable while out_valid && !out_ready.
- in_ready depends only on registered state, never on out_ready.
- Reset mid-stream discards all entries. No beat is emitted after rst_n rises until a new input is accepted.

## Test plan
- XLEN=32, 0xFFF00093 (addi x1,x0,-1) → next cycle out_valid=1, out_imm=0xFFFFFFFF, fmt=1, illegal=0.
- 0xFE000EE3 (beq -4) → imm 0xFFFFFFFC, fmt=3. 0xFF9FF06F (jal x0,-8) → imm 0xFFFFFFF8, fmt=5.
- 0x4030D093 (srai x1,x1,3) → imm 0x00000003, fmt=6. 0x0000003B at XLEN=32 → fmt=7, illegal=1, imm 0.
- XLEN=64:
  - 0x800000B7 (lui x1,0x80000) → imm 0xFFFFFFFF80000000, fmt=4.
  - 0x03F09093 (slli 63) → imm 63.
- Back-pressure:
  - Hold out_ready=0 and offer A,B,C back-to-back → A,B accepted, in_ready=0 after B, C held.
  - Then out_ready=1 → A,B,C emitted on consecutive cycles in order, with their PCs intact.
- Both entries full, assert flush together with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flush-cycle beat is never emitted.
- rst_n low mid-stream → all outputs return to reset values immediately.
